// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between requesters A and B.
// After reset it sweeps INIT_VALUE into every location before granting any command.
module bram_rr_arbiter #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDRESS_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                     clk,
  input  logic                     clr,

  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  output logic                     a_gnt,
  output logic                     a_rvalid,
  output logic [DATA_WIDTH-1:0]    a_rdata,

  input  logic                     b_req,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_wdata,
  output logic                     b_gnt,
  output logic                     b_rvalid,
  output logic [DATA_WIDTH-1:0]    b_rdata,

  output logic                     busy,

  output logic                     mem_n_clr,
  output logic                     mem_read_en,
  output logic                     mem_write_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

  logic [0:0]               state;
  logic [ADDRESS_WIDTH-1:0] init_cnt;
  logic                     rr_ptr;

  logic                     sweep;
  logic                     run;
  logic                     any_gnt;

  logic                     cmd_vld_p1;
  logic                     cmd_we_p1;
  logic                     cmd_own_p1;
  logic [ADDRESS_WIDTH-1:0] cmd_addr_p1;
  logic [DATA_WIDTH-1:0]    cmd_wdata_p1;

  logic                     rd_vld_p2;
  logic                     rd_own_p2;

  logic [DATA_WIDTH-1:0]    a_rdata_hold;
  logic [DATA_WIDTH-1:0]    b_rdata_hold;

  // clr gates everything combinationally so nothing is granted or issued while reset is held
  assign sweep = (state == ST_INIT) && !clr;
  assign run   = (state == ST_RUN)  && !clr;
  assign busy  = clr || (state == ST_INIT);

  // ---- stage p0: arbitration ----
  assign a_gnt   = run && a_req && (!b_req || (rr_ptr == PORT_A));
  assign b_gnt   = run && b_req && (!a_req || (rr_ptr == PORT_B));
  assign any_gnt = a_gnt || b_gnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      rr_ptr   <= PORT_A;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_ADDR) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (any_gnt) begin
            rr_ptr <= a_gnt ? PORT_B : PORT_A;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // ---- stage p1: command register feeding the BRAM ----
  // During the sweep the address/data registers track the init writes, so after the
  // sweep the idle BRAM inputs hold the last swept location instead of jumping back.
  always_ff @(posedge clk) begin
    if (clr) begin
      cmd_vld_p1   <= 1'b0;
      cmd_we_p1    <= 1'b0;
      cmd_own_p1   <= PORT_A;
      cmd_addr_p1  <= '0;
      cmd_wdata_p1 <= '0;
    end else if (state == ST_INIT) begin
      cmd_vld_p1   <= 1'b0;
      cmd_addr_p1  <= init_cnt;
      cmd_wdata_p1 <= INIT_VALUE;
    end else begin
      cmd_vld_p1 <= any_gnt;
      if (any_gnt) begin
        cmd_we_p1    <= a_gnt ? a_we    : b_we;
        cmd_own_p1   <= a_gnt ? PORT_A  : PORT_B;
        cmd_addr_p1  <= a_gnt ? a_addr  : b_addr;
        cmd_wdata_p1 <= a_gnt ? a_wdata : b_wdata;
      end
    end
  end

  assign mem_n_clr    = ~clr;
  assign mem_write_en = sweep || (run && cmd_vld_p1 && cmd_we_p1);
  assign mem_read_en  = run && cmd_vld_p1 && !cmd_we_p1;
  assign mem_addr     = sweep ? init_cnt   : cmd_addr_p1;
  assign mem_data_in  = sweep ? INIT_VALUE : cmd_wdata_p1;

  // ---- stage p2: read return, owner tag travels with the read ----
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_vld_p2 <= 1'b0;
      rd_own_p2 <= PORT_A;
    end else begin
      rd_vld_p2 <= mem_read_en;
      rd_own_p2 <= cmd_own_p1;
    end
  end

  assign a_rvalid = rd_vld_p2 && (rd_own_p2 == PORT_A) && !clr;
  assign b_rvalid = rd_vld_p2 && (rd_own_p2 == PORT_B) && !clr;

  // BRAM output is live only in the return cycle; the hold registers keep it afterwards
  always_ff @(posedge clk) begin
    if (a_rvalid) begin
      a_rdata_hold <= mem_data_out;
    end
    if (b_rvalid) begin
      b_rdata_hold <= mem_data_out;
    end
  end

  assign a_rdata = a_rvalid ? mem_data_out : a_rdata_hold;
  assign b_rdata = b_rvalid ? mem_data_out : b_rdata_hold;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter: two instances (INIT_VALUE 0 and 0xA5A5A5A5)
// share stimulus, each backed by its own behavioural single-port BRAM.
module tb_bram_rr_arbiter;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam logic [DW-1:0] IV1 = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic clr;
  logic a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic a_gnt, a_rvalid, b_gnt, b_rvalid, busy;
  logic [DW-1:0] a_rdata, b_rdata;
  logic m_n_clr, m_read_en, m_write_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data_in, m_data_out;

  logic d1_a_gnt, d1_a_rvalid, d1_b_gnt, d1_b_rvalid, d1_busy;
  logic [DW-1:0] d1_a_rdata, d1_b_rdata;
  logic d1_n_clr, d1_read_en, d1_write_en;
  logic [AW-1:0] d1_addr;
  logic [DW-1:0] d1_data_in, d1_data_out;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_rr_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .INIT_VALUE(32'h0)) dut (
    .clk(clk), .clr(clr),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .busy(busy),
    .mem_n_clr(m_n_clr), .mem_read_en(m_read_en), .mem_write_en(m_write_en),
    .mem_addr(m_addr), .mem_data_in(m_data_in), .mem_data_out(m_data_out)
  );

  bram_rr_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .INIT_VALUE(IV1)) dut1 (
    .clk(clk), .clr(clr),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(d1_a_gnt), .a_rvalid(d1_a_rvalid), .a_rdata(d1_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(d1_b_gnt), .b_rvalid(d1_b_rvalid), .b_rdata(d1_b_rdata),
    .busy(d1_busy),
    .mem_n_clr(d1_n_clr), .mem_read_en(d1_read_en), .mem_write_en(d1_write_en),
    .mem_addr(d1_addr), .mem_data_in(d1_data_in), .mem_data_out(d1_data_out)
  );

  // behavioural single-port BRAMs: read data appears the cycle after read_en
  always_ff @(posedge clk) begin
    if (m_write_en) mem0[m_addr] <= m_data_in;
    if (m_read_en)  m_data_out <= mem0[m_addr];
    if (d1_write_en) mem1[d1_addr] <= d1_data_in;
    if (d1_read_en)  d1_data_out <= mem1[d1_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expects clr already low and inputs settled; checks the full sweep and leaves
  // the bench in the first RUN cycle
  task automatic init_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      check("init_busy", 32'(busy), 1);
      check("init_we", 32'(m_write_en), 1);
      check("init_re", 32'(m_read_en), 0);
      check("init_addr", 32'(m_addr), i);
      check("init_data0", m_data_in, 32'h0);
      check("init_data1", d1_data_in, IV1);
      check("init_a_gnt", 32'(a_gnt), 0);
      check("init_b_gnt", 32'(b_gnt), 0);
      check("init_rvalid", 32'({a_rvalid, b_rvalid}), 0);
      step();
    end
  endtask

  initial begin
    clr = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    step();

    // reset state
    check("rst_busy", 32'(busy), 1);
    check("rst_we", 32'(m_write_en), 0);
    check("rst_re", 32'(m_read_en), 0);
    check("rst_addr", 32'(m_addr), 0);
    check("rst_data_in", m_data_in, 0);
    check("rst_gnt", 32'({a_gnt, b_gnt}), 0);
    check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 0);
    check("rst_n_clr", 32'(m_n_clr), 0);

    // A holds a read of addr 0 throughout the sweep
    clr = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd0;
    #1;
    check("run_n_clr", 32'(m_n_clr), 1);
    init_sweep();
    check("run_busy", 32'(busy), 0);
    check("first_a_gnt", 32'(a_gnt), 1);
    step();
    a_req = 1'b0;
    #1;
    check("first_re", 32'(m_read_en), 1);
    check("first_addr", 32'(m_addr), 0);
    check("first_a_rvalid_early", 32'(a_rvalid), 0);
    step();
    check("first_a_rvalid", 32'(a_rvalid), 1);
    check("first_a_rdata0", a_rdata, 32'h0);
    check("first_a_rdata1", d1_a_rdata, IV1);
    step();

    // A writes 32 to addr 10, then reads it back
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'd10; a_wdata = 32'd32;
    #1;
    check("wr10_gnt", 32'(a_gnt), 1);
    step();
    a_we = 1'b0;
    #1;
    check("rd10_gnt", 32'(a_gnt), 1);
    check("wr10_we", 32'(m_write_en), 1);
    check("wr10_re", 32'(m_read_en), 0);
    check("wr10_addr", 32'(m_addr), 10);
    check("wr10_data", m_data_in, 32'd32);
    step();
    a_req = 1'b0;
    #1;
    check("rd10_re", 32'(m_read_en), 1);
    check("rd10_we", 32'(m_write_en), 0);
    check("rd10_addr", 32'(m_addr), 10);
    check("rd10_rvalid_early", 32'(a_rvalid), 0);
    step();
    check("rd10_rvalid", 32'(a_rvalid), 1);
    check("rd10_rdata", a_rdata, 32'd32);
    check("rd10_b_rvalid", 32'(b_rvalid), 0);
    step();
    check("rd10_pulse", 32'(a_rvalid), 0);
    check("rd10_hold", a_rdata, 32'd32);
    check("idle_en", 32'({m_read_en, m_write_en}), 0);
    check("idle_addr_hold", 32'(m_addr), 10);

    // seed addr 1 via A and addr 2 via B (leaves the pointer on A)
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'd1; a_wdata = 32'h11;
    #1;
    check("seed_a_gnt", 32'(a_gnt), 1);
    step();
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 6'd2; b_wdata = 32'h22;
    #1;
    check("seed_b_gnt", 32'(b_gnt), 1);
    step();
    b_req = 1'b0;
    #1;
    step();

    // both reading continuously: grants alternate A,B,A,B
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd2;
    #1;
    check("c0_a_gnt", 32'(a_gnt), 1);
    check("c0_b_gnt", 32'(b_gnt), 0);
    step();
    check("c1_a_gnt", 32'(a_gnt), 0);
    check("c1_b_gnt", 32'(b_gnt), 1);
    check("c1_re", 32'(m_read_en), 1);
    check("c1_addr", 32'(m_addr), 1);
    step();
    check("c2_a_gnt", 32'(a_gnt), 1);
    check("c2_b_gnt", 32'(b_gnt), 0);
    check("c2_re", 32'(m_read_en), 1);
    check("c2_addr", 32'(m_addr), 2);
    check("c2_a_rvalid", 32'(a_rvalid), 1);
    check("c2_a_rdata", a_rdata, 32'h11);
    check("c2_b_rvalid", 32'(b_rvalid), 0);
    step();
    check("c3_a_gnt", 32'(a_gnt), 0);
    check("c3_b_gnt", 32'(b_gnt), 1);
    check("c3_addr", 32'(m_addr), 1);
    check("c3_b_rvalid", 32'(b_rvalid), 1);
    check("c3_b_rdata", b_rdata, 32'h22);
    check("c3_a_rvalid", 32'(a_rvalid), 0);
    step();
    a_req = 1'b0; b_req = 1'b0;
    #1;
    check("c4_re", 32'(m_read_en), 1);
    check("c4_addr", 32'(m_addr), 2);
    check("c4_a_rvalid", 32'(a_rvalid), 1);
    check("c4_a_rdata", a_rdata, 32'h11);
    step();
    check("c5_b_rvalid", 32'(b_rvalid), 1);
    check("c5_b_rdata", b_rdata, 32'h22);
    check("c5_re", 32'(m_read_en), 0);

    // same cycle: A writes addr 5, B reads addr 5; A goes first
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'd5; a_wdata = 32'hDEADBEEF;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd5;
    #1;
    check("raw_a_gnt", 32'(a_gnt), 1);
    check("raw_b_wait", 32'(b_gnt), 0);
    step();
    a_req = 1'b0;
    #1;
    check("raw_b_gnt", 32'(b_gnt), 1);
    check("raw_we", 32'(m_write_en), 1);
    check("raw_addr", 32'(m_addr), 5);
    step();
    b_req = 1'b0;
    #1;
    check("raw_re", 32'(m_read_en), 1);
    step();
    check("raw_b_rvalid", 32'(b_rvalid), 1);
    check("raw_b_rdata0", b_rdata, 32'hDEADBEEF);
    check("raw_b_rdata1", d1_b_rdata, 32'hDEADBEEF);
    step();

    // B reads never-written addr 63
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd63;
    #1;
    check("r63_gnt", 32'(b_gnt), 1);
    step();
    b_req = 1'b0;
    #1;
    step();
    check("r63_rvalid", 32'(b_rvalid), 1);
    check("r63_rdata0", b_rdata, 32'h0);
    check("r63_rdata1", d1_b_rdata, IV1);
    step();

    // reset one cycle after a read grant: read is dropped, sweep restarts, pointer back to A
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd10;
    #1;
    check("abort_gnt", 32'(a_gnt), 1);
    step();
    clr = 1'b1; a_req = 1'b0;
    #1;
    check("abort_re", 32'(m_read_en), 0);
    check("abort_busy", 32'(busy), 1);
    check("abort_n_clr", 32'(m_n_clr), 0);
    step();
    clr = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd2;
    #1;
    init_sweep();
    check("post_busy", 32'(busy), 0);
    check("post_a_gnt", 32'(a_gnt), 1);
    check("post_b_gnt", 32'(b_gnt), 0);
    step();
    check("post2_a_gnt", 32'(a_gnt), 0);
    check("post2_b_gnt", 32'(b_gnt), 1);
    a_req = 1'b0; b_req = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
